// File: rtl/tcp_msg_slot_tracker.sv
// Per-flow slot ring tracker: request -> resp_val 2 cycles later, held until resp_rdy; adjust retires in 2 cycles.
// Optional TCP_MSG_SLOT_STATS_EN adds saturating alloc/reject/adj_err counters.
module tcp_msg_slot_tracker #(
  parameter int FLOWID_W = 6,
  parameter int PTR_W    = 32,
  parameter int IDX_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_val,
  input  logic [FLOWID_W-1:0] init_flowid,
  input  logic [PTR_W-1:0]    init_bufptr,
  input  logic [PTR_W:0]      init_cap,
  input  logic                req_val,
  input  logic [FLOWID_W-1:0] req_flowid,
  input  logic [PTR_W:0]      req_len,
  output logic                req_rdy,
  input  logic                adj_val,
  input  logic [FLOWID_W-1:0] adj_flowid,
  input  logic [IDX_W:0]      adj_idx,
  output logic                adj_rdy,
  output logic                resp_val,
  output logic [FLOWID_W-1:0] resp_flowid,
  output logic [PTR_W-1:0]    resp_bufptr,
  output logic [IDX_W:0]      resp_idx,
  output logic [PTR_W:0]      resp_len,
  output logic [PTR_W:0]      resp_cap,
  input  logic                resp_rdy,
`ifdef TCP_MSG_SLOT_STATS_EN
  output logic [31:0]         stat_alloc,
  output logic [31:0]         stat_reject,
  output logic [31:0]         stat_adj_err,
`endif
  output logic                adj_err
);

  localparam int DEPTH = 1 << FLOWID_W;
  localparam logic [IDX_W:0] IDX_ONE = 1;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  state_t              state_q;
  logic                is_adj_q;
  logic [FLOWID_W-1:0] flowid_q;
  logic [PTR_W:0]      len_q;
  logic [IDX_W:0]      adjidx_q;

  logic [PTR_W-1:0]    bufptr_q [DEPTH];
  logic [PTR_W:0]      cap_q    [DEPTH];
  logic [IDX_W:0]      prod_q   [DEPTH];
  logic [IDX_W:0]      cons_q   [DEPTH];

  logic                resp_val_q;
  logic [FLOWID_W-1:0] resp_flowid_q;
  logic [PTR_W-1:0]    resp_bufptr_q;
  logic [IDX_W:0]      resp_idx_q;
  logic [PTR_W:0]      resp_len_q;
  logic [PTR_W:0]      resp_cap_q;
  logic                adj_err_q;

  logic [PTR_W-1:0]    cur_bufptr;
  logic [PTR_W:0]      cur_cap;
  logic [IDX_W:0]      cur_prod;
  logic [IDX_W:0]      cur_cons;
  logic                full;
  logic                alloc;
  logic [PTR_W:0]      grant_len;
  logic [PTR_W:0]      resp_len_d;
  logic [IDX_W:0]      prod_d;
  logic [IDX_W:0]      adj_dist;
  logic [IDX_W:0]      occupancy;
  logic                adj_legal;

  assign req_rdy = (state_q == IDLE) && !init_val && !adj_val && req_val;
  assign adj_rdy = (state_q == IDLE) && !init_val && adj_val;

  always_comb begin
    cur_bufptr = bufptr_q[flowid_q];
    cur_cap    = cap_q[flowid_q];
    cur_prod   = prod_q[flowid_q];
    cur_cons   = cons_q[flowid_q];
    // Same low bits with differing wrap bits means the ring is full.
    full       = (cur_prod[IDX_W-1:0] == cur_cons[IDX_W-1:0]) &&
                 (cur_prod[IDX_W] != cur_cons[IDX_W]);
    alloc      = !full && (cur_cap != '0);
    grant_len  = (len_q < cur_cap) ? len_q : cur_cap;
    resp_len_d = alloc ? grant_len : '0;
    prod_d     = cur_prod + IDX_ONE;
    adj_dist   = adjidx_q - cur_cons;
    occupancy  = cur_prod - cur_cons;
    adj_legal  = (adj_dist <= occupancy);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      is_adj_q      <= 1'b0;
      flowid_q      <= '0;
      len_q         <= '0;
      adjidx_q      <= '0;
      resp_val_q    <= 1'b0;
      resp_flowid_q <= '0;
      resp_bufptr_q <= '0;
      resp_idx_q    <= '0;
      resp_len_q    <= '0;
      resp_cap_q    <= '0;
      adj_err_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        bufptr_q[i] <= '0;
        cap_q[i]    <= '0;
        prod_q[i]   <= '0;
        cons_q[i]   <= '0;
      end
    end else begin
      adj_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (init_val) begin
            bufptr_q[init_flowid] <= init_bufptr;
            cap_q[init_flowid]    <= init_cap;
            prod_q[init_flowid]   <= '0;
            cons_q[init_flowid]   <= '0;
          end else if (adj_val) begin
            is_adj_q <= 1'b1;
            flowid_q <= adj_flowid;
            adjidx_q <= adj_idx;
            state_q  <= RD;
          end else if (req_val) begin
            is_adj_q <= 1'b0;
            flowid_q <= req_flowid;
            len_q    <= req_len;
            state_q  <= RD;
          end
        end
        RD: begin
          if (is_adj_q) begin
            if (adj_legal) cons_q[flowid_q] <= adjidx_q;
            else           adj_err_q        <= 1'b1;
            state_q <= IDLE;
          end else begin
            resp_val_q    <= 1'b1;
            resp_flowid_q <= flowid_q;
            resp_bufptr_q <= cur_bufptr;
            resp_idx_q    <= cur_prod;
            resp_len_q    <= resp_len_d;
            resp_cap_q    <= cur_cap;
            if (alloc) prod_q[flowid_q] <= prod_d;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_val    = resp_val_q;
  assign resp_flowid = resp_flowid_q;
  assign resp_bufptr = resp_bufptr_q;
  assign resp_idx    = resp_idx_q;
  assign resp_len    = resp_len_q;
  assign resp_cap    = resp_cap_q;
  assign adj_err     = adj_err_q;

`ifdef TCP_MSG_SLOT_STATS_EN
  logic [31:0] stat_alloc_q, stat_reject_q, stat_adj_err_q;
  logic        ev_alloc, ev_reject, ev_adj_err;

  assign ev_alloc   = (state_q == RD) && !is_adj_q && alloc;
  assign ev_reject  = (state_q == RD) && !is_adj_q && !alloc;
  assign ev_adj_err = (state_q == RD) && is_adj_q && !adj_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_alloc_q   <= '0;
      stat_reject_q  <= '0;
      stat_adj_err_q <= '0;
    end else begin
      if (ev_alloc && (stat_alloc_q != '1))     stat_alloc_q   <= stat_alloc_q + 32'd1;
      if (ev_reject && (stat_reject_q != '1))   stat_reject_q  <= stat_reject_q + 32'd1;
      if (ev_adj_err && (stat_adj_err_q != '1)) stat_adj_err_q <= stat_adj_err_q + 32'd1;
    end
  end

  assign stat_alloc   = stat_alloc_q;
  assign stat_reject  = stat_reject_q;
  assign stat_adj_err = stat_adj_err_q;
`endif

endmodule

// File: tb/tb_tcp_msg_slot_tracker.sv
// Directed bench for tcp_msg_slot_tracker with a 4-slot ring (IDX_W=2).
module tb_tcp_msg_slot_tracker;
  localparam int FLOWID_W = 6;
  localparam int PTR_W    = 32;
  localparam int IDX_W    = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                init_val = 1'b0;
  logic [FLOWID_W-1:0] init_flowid = '0;
  logic [PTR_W-1:0]    init_bufptr = '0;
  logic [PTR_W:0]      init_cap = '0;
  logic                req_val = 1'b0;
  logic [FLOWID_W-1:0] req_flowid = '0;
  logic [PTR_W:0]      req_len = '0;
  logic                req_rdy;
  logic                adj_val = 1'b0;
  logic [FLOWID_W-1:0] adj_flowid = '0;
  logic [IDX_W:0]      adj_idx = '0;
  logic                adj_rdy;
  logic                resp_val;
  logic [FLOWID_W-1:0] resp_flowid;
  logic [PTR_W-1:0]    resp_bufptr;
  logic [IDX_W:0]      resp_idx;
  logic [PTR_W:0]      resp_len;
  logic [PTR_W:0]      resp_cap;
  logic                resp_rdy = 1'b1;
  logic                adj_err;
`ifdef TCP_MSG_SLOT_STATS_EN
  logic [31:0]         stat_alloc, stat_reject, stat_adj_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tcp_msg_slot_tracker #(.FLOWID_W(FLOWID_W), .PTR_W(PTR_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_val(init_val), .init_flowid(init_flowid), .init_bufptr(init_bufptr), .init_cap(init_cap),
    .req_val(req_val), .req_flowid(req_flowid), .req_len(req_len), .req_rdy(req_rdy),
    .adj_val(adj_val), .adj_flowid(adj_flowid), .adj_idx(adj_idx), .adj_rdy(adj_rdy),
    .resp_val(resp_val), .resp_flowid(resp_flowid), .resp_bufptr(resp_bufptr),
    .resp_idx(resp_idx), .resp_len(resp_len), .resp_cap(resp_cap), .resp_rdy(resp_rdy),
`ifdef TCP_MSG_SLOT_STATS_EN
    .stat_alloc(stat_alloc), .stat_reject(stat_reject), .stat_adj_err(stat_adj_err),
`endif
    .adj_err(adj_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input int flow, input int idx, input int len,
                          input int bufp, input int cap);
    chk({tag, ".val"},    64'(resp_val), 64'd1);
    chk({tag, ".flowid"}, 64'(resp_flowid), 64'(flow));
    chk({tag, ".bufptr"}, 64'(resp_bufptr), 64'(bufp));
    chk({tag, ".idx"},    64'(resp_idx), 64'(idx));
    chk({tag, ".len"},    64'(resp_len), 64'(len));
    chk({tag, ".cap"},    64'(resp_cap), 64'(cap));
  endtask

  task automatic do_init(input int flow, input int bufp, input int cap);
    @(posedge clk); #1;
    init_val = 1'b1; init_flowid = FLOWID_W'(flow);
    init_bufptr = PTR_W'(bufp); init_cap = (PTR_W+1)'(cap);
    req_val = 1'b1; adj_val = 1'b1;
    @(negedge clk);
    chk("init.req_rdy", 64'(req_rdy), 64'd0);
    chk("init.adj_rdy", 64'(adj_rdy), 64'd0);
    @(posedge clk); #1;
    init_val = 1'b0; req_val = 1'b0; adj_val = 1'b0;
  endtask

  // Leaves the DUT in RESP with resp_rdy=1, so the next posedge completes the handshake.
  task automatic do_req(input string tag, input int flow, input int len,
                        input int e_idx, input int e_len, input int e_buf, input int e_cap);
    @(posedge clk); #1;
    req_val = 1'b1; req_flowid = FLOWID_W'(flow); req_len = (PTR_W+1)'(len);
    @(negedge clk);
    chk({tag, ".req_rdy"}, 64'(req_rdy), 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    @(negedge clk);
    chk({tag, ".early"}, 64'(resp_val), 64'd0);
    @(negedge clk);
    chk_resp(tag, flow, e_idx, e_len, e_buf, e_cap);
  endtask

  task automatic do_adj(input string tag, input int flow, input int idx, input int e_err);
    @(posedge clk); #1;
    adj_val = 1'b1; adj_flowid = FLOWID_W'(flow); adj_idx = (IDX_W+1)'(idx);
    @(negedge clk);
    chk({tag, ".adj_rdy"}, 64'(adj_rdy), 64'd1);
    @(posedge clk); #1;
    adj_val = 1'b0;
    @(negedge clk);
    chk({tag, ".err_early"}, 64'(adj_err), 64'd0);
    @(negedge clk);
    chk({tag, ".adj_err"}, 64'(adj_err), 64'(e_err));
    chk({tag, ".no_resp"}, 64'(resp_val), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst.resp_val", 64'(resp_val), 64'd0);
    chk("rst.resp_len", 64'(resp_len), 64'd0);
    chk("rst.adj_err",  64'(adj_err),  64'd0);
    chk("rst.req_rdy",  64'(req_rdy),  64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_init(3, 'h1000, 512);
    do_req("f3_first", 3, 100, 0, 100, 'h1000, 512);
    do_req("f3_clamp", 3, 600, 1, 512, 'h1000, 512);
    do_adj("f3_adj_bad", 3, 3, 1);
    do_adj("f3_adj_ok",  3, 2, 0);

    do_init(5, 'h2000, 64);
    do_req("ring0", 5, 10, 0, 10, 'h2000, 64);
    do_req("ring1", 5, 10, 1, 10, 'h2000, 64);
    do_req("ring2", 5, 10, 2, 10, 'h2000, 64);
    do_req("ring3", 5, 10, 3, 10, 'h2000, 64);
    do_req("ring_full", 5, 10, 4, 0, 'h2000, 64);
    do_adj("ring_adj2", 5, 2, 0);
    do_req("ring_after", 5, 10, 4, 10, 'h2000, 64);
    do_req("ring_fill", 5, 10, 5, 10, 'h2000, 64);

    // Ring is full here; the request only succeeds if the adjust is applied first.
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    adj_val = 1'b1; adj_flowid = 6'd5; adj_idx = 3'd4;
    req_val = 1'b1; req_flowid = 6'd5; req_len = 33'd10;
    @(negedge clk);
    chk("both.adj_rdy", 64'(adj_rdy), 64'd1);
    chk("both.req_rdy", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    adj_val = 1'b0;
    @(negedge clk);
    chk("both.req_rdy_rd", 64'(req_rdy), 64'd0);
    @(negedge clk);
    chk("both.req_rdy2", 64'(req_rdy), 64'd1);
    chk("both.adj_err",  64'(adj_err), 64'd0);
    @(posedge clk); #1;
    req_val = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_resp("stall", 5, 6, 10, 'h2000, 64);
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("stall.done", 64'(resp_val), 64'd0);

    // Reset while a response is pending.
    @(posedge clk); #1;
    resp_rdy = 1'b0;
    req_val = 1'b1; req_flowid = 6'd3; req_len = 33'd50;
    @(negedge clk);
    chk("rstmid.req_rdy", 64'(req_rdy), 64'd1);
    @(posedge clk); #1;
    req_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_resp("rstmid", 3, 2, 50, 'h1000, 512);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.val_clr", 64'(resp_val), 64'd0);
    chk("rstmid.len_clr", 64'(resp_len), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; resp_rdy = 1'b1;
    do_req("post_rst", 3, 100, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
